mem_stage: RTL and testbench

Memory-access stage of the five-stage RV32 pipeline, sitting between the EX/MEM register and the writeback stage. It drives the data-memory request bus with a ready handshake, stalls upstream while memory is busy, and formats load data. It detects misaligned accesses and owns the MEM/WB pipeline register whose fields the writeback stage consumes: ALUResult, load_data, PCPlus4, ImmExt, ResultSrc, Rd and RegWrite.

---
 rtl/mem_stage.sv | 93 +++++++++
 tb/tb_mem_stage.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: RV32 memory-access stage, drives the data-memory bus, formats loads and owns the MEM/WB register.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_m,
  input  logic            MemRead_m,
  input  logic            MemWrite_m,
  input  logic [2:0]      funct3_m,
  input  logic            RegWrite_m,
  input  logic [1:0]      ResultSrc_m,
  input  logic [4:0]      Rd_m,
  input  logic [XLEN-1:0] ALUResult_m,
  input  logic [XLEN-1:0] WriteData_m,
  input  logic [XLEN-1:0] PCPlus4_m,
  input  logic [XLEN-1:0] ImmExt_m,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_m,
  output logic            misaligned_m,
  output logic            wb_valid,
  output logic            wb_RegWrite,
  output logic            wb_fault,
  output logic [1:0]      wb_ResultSrc,
  output logic [4:0]      wb_Rd,
  output logic [XLEN-1:0] wb_ALUResult,
  output logic [XLEN-1:0] wb_load_data,
  output logic [XLEN-1:0] wb_PCPlus4,
  output logic [XLEN-1:0] wb_ImmExt
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t r_state, w_next;
  logic            w_mem_op;
  logic [1:0]      w_off;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  assign w_mem_op     = valid_m & (MemRead_m | MemWrite_m);
  assign w_off        = ALUResult_m[1:0];
  assign misaligned_m = w_mem_op & (((funct3_m[1:0] == 2'b01) & w_off[0]) |
                                    ((funct3_m[1:0] == 2'b10) & (|w_off)));
  assign dmem_req     = w_mem_op & ~misaligned_m;
  assign dmem_we      = MemWrite_m;
  assign dmem_addr    = {ALUResult_m[XLEN-1:2], 2'b00};
  assign stall_m      = dmem_req & ~dmem_ready;
  assign w_byte       = dmem_rdata[{w_off, 3'b000} +: 8];
  assign w_half       = w_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  // funct3[2] selects zero extension; size 11 falls through to a full word
  always_comb begin
    dmem_be    = (funct3_m[1:0] == 2'b00) ? 4'b0001 << w_off :
                 (funct3_m[1:0] == 2'b01) ? 4'b0011 << w_off : 4'b1111;
    dmem_wdata = (funct3_m[1:0] == 2'b00) ? {4{WriteData_m[7:0]}} :
                 (funct3_m[1:0] == 2'b01) ? {2{WriteData_m[15:0]}} : WriteData_m;
    w_load     = (funct3_m[1:0] == 2'b00) ? {{24{~funct3_m[2] & w_byte[7]}}, w_byte} :
                 (funct3_m[1:0] == 2'b01) ? {{16{~funct3_m[2] & w_half[15]}}, w_half} : dmem_rdata;
  end
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (stall_m ? WAIT : IDLE) : (dmem_ready ? IDLE : WAIT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset || stall_m) begin
      wb_valid     <= 1'b0;
      wb_RegWrite  <= 1'b0;
      wb_fault     <= 1'b0;
      wb_ResultSrc <= '0;
      wb_Rd        <= '0;
      wb_ALUResult <= '0;
      wb_load_data <= '0;
      wb_PCPlus4   <= '0;
      wb_ImmExt    <= '0;
    end else begin
      wb_valid     <= valid_m;
      wb_RegWrite  <= RegWrite_m & valid_m & ~misaligned_m;
      wb_fault     <= misaligned_m;
      wb_ResultSrc <= ResultSrc_m;
      wb_Rd        <= Rd_m;
      wb_ALUResult <= ALUResult_m;
      wb_load_data <= (dmem_req & MemRead_m) ? w_load : '0;
      wb_PCPlus4   <= PCPlus4_m;
      wb_ImmExt    <= ImmExt_m;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage against a byte-level reference model.
module tb_mem_stage;
  logic        clk = 0, reset = 1;
  logic        valid_m = 0, MemRead_m = 0, MemWrite_m = 0, RegWrite_m = 0;
  logic [2:0]  funct3_m = 0;
  logic [1:0]  ResultSrc_m = 0;
  logic [4:0]  Rd_m = 0;
  logic [31:0] ALUResult_m = 0, WriteData_m = 0, PCPlus4_m = 0, ImmExt_m = 0;
  logic        dmem_req, dmem_we, dmem_ready = 0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
  logic [3:0]  dmem_be;
  logic        stall_m, misaligned_m, wb_valid, wb_RegWrite, wb_fault;
  logic [1:0]  wb_ResultSrc;
  logic [4:0]  wb_Rd;
  logic [31:0] wb_ALUResult, wb_load_data, wb_PCPlus4, wb_ImmExt;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_m(valid_m), .MemRead_m(MemRead_m), .MemWrite_m(MemWrite_m),
    .funct3_m(funct3_m), .RegWrite_m(RegWrite_m), .ResultSrc_m(ResultSrc_m), .Rd_m(Rd_m),
    .ALUResult_m(ALUResult_m), .WriteData_m(WriteData_m), .PCPlus4_m(PCPlus4_m), .ImmExt_m(ImmExt_m),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall_m(stall_m),
    .misaligned_m(misaligned_m), .wb_valid(wb_valid), .wb_RegWrite(wb_RegWrite), .wb_fault(wb_fault),
    .wb_ResultSrc(wb_ResultSrc), .wb_Rd(wb_Rd), .wb_ALUResult(wb_ALUResult),
    .wb_load_data(wb_load_data), .wb_PCPlus4(wb_PCPlus4), .wb_ImmExt(wb_ImmExt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, rw, f;
    logic [1:0] rs;
    logic [4:0] rd;
    logic [31:0] alu, ld, pc, imm;
  } wb_t;
  wb_t q[$];
  int checks = 0, failures = 0;
  bit mon_en = 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Each cycle's expected MEM/WB contents become visible one edge after they are pushed
  initial forever begin
    @(posedge clk); #2;
    if (mon_en && q.size() > 1) begin
      wb_t e;
      e = q.pop_front();
      chk("wb_valid", 32'(wb_valid), 32'(e.v));
      chk("wb_RegWrite", 32'(wb_RegWrite), 32'(e.rw));
      chk("wb_fault", 32'(wb_fault), 32'(e.f));
      chk("wb_ResultSrc", 32'(wb_ResultSrc), 32'(e.rs));
      chk("wb_Rd", 32'(wb_Rd), 32'(e.rd));
      chk("wb_ALUResult", wb_ALUResult, e.alu);
      chk("wb_load_data", wb_load_data, e.ld);
      chk("wb_PCPlus4", wb_PCPlus4, e.pc);
      chk("wb_ImmExt", wb_ImmExt, e.imm);
    end
  end

  task automatic do_op(input logic v, rd_, wr, input logic [2:0] f3, input logic rw,
                       input logic [1:0] rs, input logic [4:0] rdn,
                       input logic [31:0] alu, wd, pc4, imm, input int nwait,
                       input logic [31:0] rdat, output int stalls);
    wb_t e;
    bit mem, mis, req, stl;
    int sz, off;
    logic [31:0] be, wdat, ld, mask, sh;
    mem  = v && (rd_ || wr);
    sz   = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    off  = int'(alu[1:0]);
    mis  = mem && ((sz == 2 && off % 2 == 1) || (f3[1:0] == 2 && off != 0));
    req  = mem && !mis;
    be   = (sz == 4) ? 32'hF : ((32'h1 << sz) - 1) << off;
    wdat = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
    sh   = (sz == 4) ? rdat : rdat >> (8 * off);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * sz)) - 1;
    ld   = sh & mask;
    if (sz < 4 && !f3[2] && ld[8*sz-1]) ld = ld | ~mask;
    stalls = 0;
    for (int c = 0; c <= nwait; c++) begin
      @(posedge clk); #1;
      valid_m = v; MemRead_m = rd_; MemWrite_m = wr; funct3_m = f3; RegWrite_m = rw;
      ResultSrc_m = rs; Rd_m = rdn; ALUResult_m = alu; WriteData_m = wd; PCPlus4_m = pc4; ImmExt_m = imm;
      dmem_ready = req ? (c == nwait) : 1'($urandom);
      dmem_rdata = dmem_ready ? rdat : $urandom;
      stl = req && c < nwait;
      e = stl ? '0 : {v, rw & v & !mis, mis, rs, rdn, alu, (req && rd_) ? ld : 32'h0, pc4, imm};
      q.push_back(e);
      #1;
      chk("misaligned_m", 32'(misaligned_m), 32'(mis));
      chk("dmem_req", 32'(dmem_req), 32'(req));
      chk("stall_m", 32'(stall_m), 32'(stl));
      if (req) begin
        chk("dmem_we", 32'(dmem_we), 32'(wr));
        chk("dmem_addr", dmem_addr, {alu[31:2], 2'b00});
        chk("dmem_be", 32'(dmem_be), be);
        chk("dmem_wdata", dmem_wdata, wdat);
      end
      if (stl) stalls++;
      if (!req) break;
    end
  endtask

  initial begin
    int st;
    logic [2:0] ld_f3 [6] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_RegWrite", 32'(wb_RegWrite), 0);
    chk("rst_wb_ALUResult", wb_ALUResult, 0);
    chk("rst_wb_load_data", wb_load_data, 0);
    reset = 0;
    do_op(1, 1, 0, 3'd2, 1, 2'd1, 5'd3, 32'h100, 0, 32'h4, 0, 0, 32'hDEADBEEF, st);
    chk("lw_zero_wait_stalls", st, 0);
    do_op(1, 1, 0, 3'd0, 1, 2'd1, 5'd4, 32'h103, 0, 32'h8, 0, 2, 32'h80FFFFFF, st);
    chk("lb_wait_stalls", st, 2);
    do_op(1, 1, 0, 3'd4, 1, 2'd1, 5'd5, 32'h103, 0, 32'hC, 0, 2, 32'h80FFFFFF, st);
    chk("lbu_wait_stalls", st, 2);
    do_op(1, 0, 1, 3'd1, 0, 2'd0, 5'd0, 32'h202, 32'h1234ABCD, 32'h10, 0, 0, 0, st);
    do_op(1, 1, 0, 3'd2, 1, 2'd1, 5'd6, 32'h101, 0, 32'h14, 0, 0, 32'h11111111, st);
    do_op(1, 0, 0, 3'd0, 1, 2'd0, 5'd7, 32'h55, 0, 32'h18, 32'h9, 0, 0, st);
    do_op(1, 1, 0, 3'd2, 1, 2'd1, 5'd8, 32'h104, 0, 32'h1C, 0, 1, 32'hCAFEF00D, st);
    do_op(0, 0, 0, 3'd0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 0, st);
    @(posedge clk); #1;
    mon_en = 0; q.delete();
    valid_m = 1; MemRead_m = 1; MemWrite_m = 0; funct3_m = 3'd0; RegWrite_m = 1; Rd_m = 5'd9;
    ALUResult_m = 32'h103; dmem_ready = 0; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    chk("pre_rst_stall", 32'(stall_m), 1);
    reset = 1; #1;
    chk("rst_wait_wb_valid", 32'(wb_valid), 0);
    chk("rst_wait_wb_RegWrite", 32'(wb_RegWrite), 0);
    chk("rst_wait_wb_Rd", 32'(wb_Rd), 0);
    chk("rst_wait_wb_load_data", wb_load_data, 0);
    valid_m = 0; MemRead_m = 0; RegWrite_m = 0; Rd_m = 0; ALUResult_m = 0; dmem_ready = 1;
    reset = 0; #1;
    chk("post_rst_req", 32'(dmem_req), 0);
    @(posedge clk); #1;
    chk("post_rst_wb_valid", 32'(wb_valid), 0);
    chk("post_rst_wb_load_data", wb_load_data, 0);
    q.delete(); mon_en = 1;
    for (int i = 0; i < 300; i++) begin
      int kind;
      logic [2:0] f;
      kind = $urandom_range(0, 3);
      f = (kind == 1) ? ld_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 2));
      do_op(kind != 3, kind == 1 || (kind == 3 && 1'($urandom)), kind == 2, f, 1'($urandom),
            2'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom, st);
    end
    do_op(0, 0, 0, 3'd0, 0, 2'd0, 5'd0, 0, 0, 0, 0, 0, 0, st);
    @(posedge clk); #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
